// File: rtl/sram_pkg.sv
// Shared definitions for the masked single-port SRAM model: controller states,
// mask segment derivation and the parameter sanity check used at elaboration.
package sram_pkg;

   // Controller states; INIT is only reachable when the reset-time clear is built in
   typedef enum logic {
      INIT = 1'b0,
      IDLE = 1'b1
   } sram_state_e;

   // Number of write-mask segments per entry
   function automatic int calc_segs(input int width, input int gran);
      return (gran > 0) ? (width / gran) : 1;
   endfunction

   // True when the entry splits evenly into mask segments
   function automatic bit gran_ok(input int width, input int gran);
      return (gran > 0) && ((width % gran) == 0);
   endfunction

endpackage

// File: rtl/sram_init_seq.sv
// Reset-time clear sequencer: after reset release it walks every entry once,
// requesting a zero write per cycle, then reports completion and goes quiet.
// Used only when SRAM_RESET_CLEAR_EN is defined.
module sram_init_seq
   import sram_pkg::*;
#(
   parameter int DEPTH = 4096,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          init_we,
   output logic [AW-1:0] init_addr,
   output logic          init_done
);

   localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

   sram_state_e   state_reg;
   logic [AW-1:0] cnt_reg;
   logic          we_reg;
   logic          done_reg;

   // Clear FSM: reset parks in INIT at entry 0; one entry cleared per cycle until the last
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg <= INIT;
         cnt_reg   <= '0;
         we_reg    <= 1'b1;
         done_reg  <= 1'b0;
      end else begin
         case (state_reg)
            INIT: begin
               if (cnt_reg == LAST_ADDR) begin
                  state_reg <= IDLE;
                  we_reg    <= 1'b0;
                  done_reg  <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end
            IDLE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= INIT;
            end
         endcase
      end
   end

   assign init_we   = we_reg;
   assign init_addr = cnt_reg;
   assign init_done = done_reg;

endmodule

// File: rtl/sram_rw_masked_ext.sv
// Parametrised single-port SRAM with per-segment write mask, a registered and
// held read-data output with a valid strobe, and an optional reset-time clear
// (macro SRAM_RESET_CLEAR_EN) that zeroes every entry before requests are taken.
module sram_rw_masked_ext
   import sram_pkg::*;
#(
   parameter  int DEPTH     = 4096,
   parameter  int WIDTH     = 7,
   parameter  int MASK_GRAN = 7,
   localparam int AW        = $clog2(DEPTH),
   localparam int SEGS      = calc_segs(WIDTH, MASK_GRAN)
) (
   input  logic             RW0_clk,
   input  logic             RW0_rst_n,
   input  logic [AW-1:0]    RW0_addr,
   input  logic             RW0_en,
   input  logic             RW0_wmode,
   input  logic [SEGS-1:0]  RW0_wmask,
   input  logic [WIDTH-1:0] RW0_wdata,
   output logic [WIDTH-1:0] RW0_rdata,
   output logic             RW0_rvalid,
   output logic             RW0_ready
);

   generate
      if (!gran_ok(WIDTH, MASK_GRAN)) begin : g_bad_gran
         $error("sram_rw_masked_ext: WIDTH must be a multiple of MASK_GRAN");
      end
      if (DEPTH < 2) begin : g_bad_depth
         $error("sram_rw_masked_ext: DEPTH must be at least 2");
      end
   endgenerate

   localparam logic [AW:0] DEPTH_W = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] ram_mem [DEPTH];

   logic             ready_int;
   logic             clear_active;
   logic [AW-1:0]    clear_addr;
   logic             in_range;
   logic             accept;
   logic             wr_acc;
   logic             rd_acc;
   logic [AW-1:0]    mem_addr;
   logic [SEGS-1:0]  seg_we;
   logic [WIDTH-1:0] seg_wdata;
   logic [WIDTH-1:0] rdata_reg;
   logic             rvalid_reg;

`ifdef SRAM_RESET_CLEAR_EN
   logic          init_we;
   logic [AW-1:0] init_addr;
   logic          init_done;

   sram_init_seq #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_init_seq (
      .clk       (RW0_clk),
      .rst_n     (RW0_rst_n),
      .init_we   (init_we),
      .init_addr (init_addr),
      .init_done (init_done)
   );

   assign ready_int    = init_done;
   assign clear_active = init_we & RW0_rst_n;
   assign clear_addr   = init_addr;
`else
   // Without the clear the array is usable as soon as reset is released
   assign ready_int    = 1'b1;
   assign clear_active = 1'b0;
   assign clear_addr   = '0;
`endif

   // Ready is forced low for as long as reset is held
   assign RW0_ready = ready_int & RW0_rst_n;
   assign accept    = RW0_en & RW0_ready;
   assign in_range  = ({1'b0, RW0_addr} < DEPTH_W);
   assign wr_acc    = accept & RW0_wmode & in_range;
   assign rd_acc    = accept & ~RW0_wmode;

   // Clear writes take the port over requests; they never overlap because ready is low
   assign mem_addr = clear_active ? clear_addr : RW0_addr;

   generate
      for (genvar gi = 0; gi < SEGS; gi++) begin : g_seg
         assign seg_we[gi] = clear_active | (wr_acc & RW0_wmask[gi]);
         assign seg_wdata[gi*MASK_GRAN +: MASK_GRAN] =
            clear_active ? '0 : RW0_wdata[gi*MASK_GRAN +: MASK_GRAN];
      end
   endgenerate

   // Array write: each enabled segment is updated, the others keep their contents
   always_ff @(posedge RW0_clk) begin
      for (int s = 0; s < SEGS; s++) begin
         if (seg_we[s]) begin
            ram_mem[mem_addr][s*MASK_GRAN +: MASK_GRAN] <= seg_wdata[s*MASK_GRAN +: MASK_GRAN];
         end
      end
   end

   // Read register: captures on an accepted read (zero when out of range), holds otherwise
   always_ff @(posedge RW0_clk) begin
      if (!RW0_rst_n) begin
         rdata_reg  <= '0;
         rvalid_reg <= 1'b0;
      end else begin
         rvalid_reg <= rd_acc;
         if (rd_acc) begin
            rdata_reg <= in_range ? ram_mem[RW0_addr] : '0;
         end
      end
   end

   assign RW0_rdata  = rdata_reg;
   assign RW0_rvalid = rvalid_reg;

endmodule

// File: tb/tb_sram_rw_masked_ext.sv
// Self-checking bench for sram_rw_masked_ext (DEPTH=16, WIDTH=8, MASK_GRAN=4).
// Adapts to the SRAM_RESET_CLEAR_EN build option.
module tb_sram_rw_masked_ext;

   localparam int DEPTH = 16;
   localparam int WIDTH = 8;
   localparam int GRAN  = 4;
   localparam int SEGS  = 2;
   localparam int AW    = 4;
`ifdef SRAM_RESET_CLEAR_EN
   localparam bit FEAT = 1'b1;
`else
   localparam bit FEAT = 1'b0;
`endif

   logic             clk   = 1'b0;
   logic             rst_n = 1'b0;
   logic             en    = 1'b0;
   logic             wmode = 1'b0;
   logic [AW-1:0]    addr  = '0;
   logic [SEGS-1:0]  wmask = '0;
   logic [WIDTH-1:0] wdata = '0;
   logic [WIDTH-1:0] rdata;
   logic             rvalid;
   logic             ready;

   int total = 0;
   int bad   = 0;

   sram_rw_masked_ext #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .MASK_GRAN (GRAN)
   ) dut (
      .RW0_clk    (clk),
      .RW0_rst_n  (rst_n),
      .RW0_addr   (addr),
      .RW0_en     (en),
      .RW0_wmode  (wmode),
      .RW0_wmask  (wmask),
      .RW0_wdata  (wdata),
      .RW0_rdata  (rdata),
      .RW0_rvalid (rvalid),
      .RW0_ready  (ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   // Behavioural model: memory contents, not-ready cycles left, expected outputs
   logic [WIDTH-1:0] m_mem [DEPTH];
   bit               m_known [DEPTH];
   logic [WIDTH-1:0] m_rdata = '0;
   bit               m_rd_known = 1'b0;
   bit               m_rvalid = 1'b0;
   int               m_busy = 0;
   bit               m_live = 1'b0;

   always @(posedge clk) begin
      if (!rst_n) begin
         m_live     = 1'b1;
         m_rdata    = '0;
         m_rd_known = 1'b1;
         m_rvalid   = 1'b0;
         m_busy     = FEAT ? DEPTH : 0;
         if (FEAT) begin
            for (int i = 0; i < DEPTH; i++) begin
               m_mem[i]   = '0;
               m_known[i] = 1'b1;
            end
         end
      end else if (m_live) begin
         m_rvalid = 1'b0;
         if (m_busy > 0) begin
            m_busy--;
         end else if (en) begin
            if (wmode) begin
               for (int s = 0; s < SEGS; s++) begin
                  if (wmask[s]) m_mem[addr][s*GRAN +: GRAN] = wdata[s*GRAN +: GRAN];
               end
               m_known[addr] = m_known[addr] | (&wmask);
            end else begin
               m_rdata    = m_mem[addr];
               m_rd_known = m_known[addr];
               m_rvalid   = 1'b1;
            end
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge
   always @(negedge clk) begin
      if (m_live) begin
         chk("cyc_ready", {31'b0, ready}, {31'b0, (rst_n && m_busy == 0)});
         chk("cyc_rvalid", {31'b0, rvalid}, {31'b0, m_rvalid});
         if (m_rd_known) chk("cyc_rdata", {24'b0, rdata}, {24'b0, m_rdata});
      end
   end

   task automatic drive(input logic e, input logic wm, input logic [AW-1:0] a,
                        input logic [WIDTH-1:0] d, input logic [SEGS-1:0] m);
      @(posedge clk);
      #2;
      en = e; wmode = wm; addr = a; wdata = d; wmask = m;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [WIDTH-1:0] d, input logic [SEGS-1:0] m);
      drive(1'b1, 1'b1, a, d, m);
      $display("write addr=%0d data=%02h mask=%b", a, d, m);
   endtask

   task automatic read_chk(input logic [AW-1:0] a, input logic [WIDTH-1:0] exp, input string nm);
      drive(1'b1, 1'b0, a, '0, '0);
      drive(1'b0, 1'b0, '0, '0, '0);
      @(negedge clk);
      $display("read  addr=%0d data=%02h rvalid=%0b", a, rdata, rvalid);
      chk(nm, {24'b0, rdata}, {24'b0, exp});
      chk({nm, "_rvalid"}, {31'b0, rvalid}, 32'd1);
   endtask

   task automatic count_not_ready(output int n);
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (ready) break;
         n++;
      end
   endtask

   logic [WIDTH-1:0] stream_exp [3];
   int n_nr;

   initial begin
      stream_exp[0] = 8'h11;
      stream_exp[1] = 8'h22;
      stream_exp[2] = 8'h33;

      // Reset
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdata", {24'b0, rdata}, 32'd0);
      chk("rst_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_ready", {31'b0, ready}, 32'd0);

      // Release with a write pending; dropped while not ready
      @(posedge clk);
      #2;
      rst_n = 1'b1; en = 1'b1; wmode = 1'b1; addr = 4'd5; wdata = 8'h77; wmask = 2'b11;
      n_nr = 0;
      while (n_nr < 100) begin
         @(negedge clk);
         if (ready) break;
         n_nr++;
         if (n_nr == 4) en = 1'b0;
      end
      en = 1'b0;
      $display("release: not-ready cycles=%0d", n_nr);
      chk("not_ready_cycles", n_nr, FEAT ? 32'd16 : 32'd0);

`ifdef SRAM_RESET_CLEAR_EN
      for (int a = 0; a < DEPTH; a++) read_chk(AW'(a), 8'h00, "clear_rd");
      read_chk(4'd5, 8'h00, "drop_wr");
`endif

      // Masked write
      wr(4'd3, 8'hA5, 2'b11);
      wr(4'd3, 8'h3C, 2'b01);
      read_chk(4'd3, 8'hAC, "masked");

      // Hold through a write and idle cycles
      wr(4'd3, 8'hFF, 2'b11);
      drive(1'b0, 1'b0, '0, '0, '0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         $display("hold  cycle=%0d rdata=%02h rvalid=%0b", i, rdata, rvalid);
         chk("hold_rdata", {24'b0, rdata}, 32'h0000_00AC);
         chk("hold_rvalid", {31'b0, rvalid}, 32'd0);
      end

      // Streaming reads
      wr(4'd0, 8'h11, 2'b11);
      wr(4'd1, 8'h22, 2'b11);
      wr(4'd2, 8'h33, 2'b11);
      drive(1'b1, 1'b0, 4'd0, '0, '0);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #2;
         if (i < 2) addr = AW'(i + 1);
         else en = 1'b0;
         @(negedge clk);
         $display("stream idx=%0d rdata=%02h rvalid=%0b", i, rdata, rvalid);
         chk("stream_rdata", {24'b0, rdata}, {24'b0, stream_exp[i]});
         chk("stream_rvalid", {31'b0, rvalid}, 32'd1);
      end

      // Reset right after a read: in-flight result discarded
      drive(1'b1, 1'b0, 4'd3, '0, '0);
      @(posedge clk);
      #2;
      rst_n = 1'b0; en = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mid_rdata", {24'b0, rdata}, 32'd0);
      chk("rst_mid_rvalid", {31'b0, rvalid}, 32'd0);
      chk("rst_mid_ready", {31'b0, ready}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

`ifdef SRAM_RESET_CLEAR_EN
      // Re-assert reset in init cycle 8; the clear must restart in full
      repeat (8) @(negedge clk);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      @(negedge clk);
      chk("rst_init_rdata", {24'b0, rdata}, 32'd0);
      chk("rst_init_rvalid", {31'b0, rvalid}, 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      count_not_ready(n_nr);
      $display("re-release: not-ready cycles=%0d", n_nr);
      chk("reinit_cycles", n_nr, 32'd16);
      read_chk(4'd3, 8'h00, "recleared");
`else
      count_not_ready(n_nr);
      $display("re-release: not-ready cycles=%0d", n_nr);
      chk("rerelease_cycles", n_nr, 32'd0);
      read_chk(4'd3, 8'hFF, "retained");
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_rw_masked_ext.md
# sram_rw_masked_ext

Parametrised single-port SRAM macro model, successor to the fixed-size `*_ext` array wrappers. Adds:
- configurable depth, width and write-mask granularity;
- a registered, held read-data output with a valid strobe;
- an optional reset-time clear sequencer that zeroes the array before accepting requests.

It sits wherever frontend or backend tables (predictor, tag and meta arrays) instantiate an `*_ext` memory.

## Interface
- `DEPTH`, 4096: number of entries, ≥2; need not be a power of two.
- `WIDTH`, 7: bits per entry.
- `MASK_GRAN`, 7: bits per mask segment; `WIDTH` must be a multiple of it. `SEGS = WIDTH/MASK_GRAN`.
- `AW`, `$clog2(DEPTH)`: address width (derived, not overridden).

Ports:
- `RW0_clk` in 1: sole clock; all state updates on the rising edge.
- `RW0_rst_n` in 1: synchronous, active-low reset.
- `RW0_addr` in `AW`: entry address.
- `RW0_en` in 1: request enable.
- `RW0_wmode` in 1: 1 = write, 0 = read.
- `RW0_wmask` in `SEGS`: per-segment write enable; bit i covers `wdata[i*MASK_GRAN +: MASK_GRAN]`.
- `RW0_wdata` in `WIDTH`: write data.
- `RW0_rdata` out `WIDTH`: registered read data, held between reads.
- `RW0_rvalid` out 1: one-cycle pulse when `RW0_rdata` updates.
- `RW0_ready` out 1: requests accepted only while high.

## Operation
- Accept = `RW0_en && RW0_ready`. Requests while not ready are dropped silently.
- Write (accept && wmode): segment i of `ram[addr]` is updated iff `wmask[i]`; other segments keep their value. An all-zero mask is a legal no-op.
- Read (accept && !wmode): `ram[addr]` is captured into the output register one edge later. `RW0_rvalid` is 1 for that one cycle.
- `RW0_rdata` holds the last read result indefinitely: through writes, idle cycles and non-ready periods. A write to the same address does not alter the held value.
- Out-of-range address (`addr ≥ DEPTH`):
  - write is dropped;
  - read returns 0 with `rvalid` = 1.
- States: `INIT`, `IDLE`.
  - `IDLE`: `ready` = 1.
  - `INIT` exists only with the clear feature (see Configuration).

## Timing
- While `RW0_rst_n` = 0 at an edge:
  - `rdata` ← 0, `rvalid` ← 0, clear counter ← 0;
  - state ← `INIT` (feature on) or `IDLE` (feature off);
  - `ready` is 0 during reset.
- Read latency is 1 cycle: address at edge N gives data and `rvalid` after edge N+1's update, i.e. visible in cycle N+1.
- Write at edge N is visible to a read issued at edge N+1 (data out in cycle N+2).
- Back-to-back reads at full rate give one result per cycle, in order.
- Reset asserted mid-operation:
  - in-flight read is discarded (`rvalid` forced 0);
  - array contents are undefined if reset lands mid-write; otherwise they are retained (feature off) or re-cleared (feature on);
  - clear sequence restarts from entry 0.

## Configuration
- Macro `SRAM_RESET_CLEAR_EN`.
- Defined:
  - after reset release, state `INIT` writes 0 to entry `cnt` each cycle, `cnt` = 0..DEPTH-1;
  - `ready` = 0 throughout;
  - after writing entry DEPTH-1, state → `IDLE` and `ready` = 1 on the next cycle;
  - total not-ready time after release is exactly `DEPTH` cycles.
- Undefined:
  - no `INIT` state and no counter;
  - `ready` = 1 from the first cycle after reset release;
  - array contents are untouched by reset (X in simulation unless otherwise initialised).

## Structure
- Shared package `sram_pkg` holds:
  - state enum `sram_state_e` {`INIT`, `IDLE`};
  - the `SEGS` derivation;
  - an elaboration-time check that `WIDTH % MASK_GRAN == 0`.
- Sub-module `sram_init_seq` contains the clear FSM and counter, and drives:
  - `init_we`;
  - `init_addr`;
  - `init_done`.
- It is instantiated only under `SRAM_RESET_CLEAR_EN`.
- The top level muxes init writes over the request port.

## Test plan
Bench parameters: `DEPTH`=16, `WIDTH`=8, `MASK_GRAN`=4.
- Clear-on-reset (macro defined): release reset → `ready` = 0 for exactly 16 cycles, then 1; reads of addresses 0..15 all return 0x00.
- Masked write: write 0xA5 with mask 2'b11 to addr 3, then 0x3C with mask 2'b01 to addr 3; read addr 3 → 0xAC one cycle later with `rvalid` = 1.
- Hold: after reading 0xAC from addr 3, write 0xFF to addr 3 and idle 5 cycles → `rdata` stays 0xAC and `rvalid` stays 0.
- Streaming: reads of addrs 0,1,2 on consecutive cycles (preloaded 0x11, 0x22, 0x33) → `rdata` shows 0x11, 0x22, 0x33 on consecutive cycles with `rvalid` high for all three.
- Drop while not ready: issue a write of 0x77 to addr 5 during `INIT` → after init, a read of addr 5 returns 0x00.
- Reset mid-init: assert `RW0_rst_n` = 0 at init cycle 8, release → `ready` = 0 for a full 16 cycles again, and `rdata` = 0 and `rvalid` = 0 during reset.
